// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer state
// encoding and default widths.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks ptr over every entry, requesting a zero
// write each cycle, and holds busy until the last entry has been cleared.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Exit on the last entry without advancing ptr, so it never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      RF_CLEAR: begin
        if (ptr_q == '1) begin
          state_d = RF_RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
    endcase
  end

  always_comb begin
    busy_o     = (state_q == RF_CLEAR);
    clr_we_o   = (state_q == RF_CLEAR);
    clr_addr_o = ptr_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on address clash),
// NUM_RD combinational read ports with same-cycle write bypass, hardware clear.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr0_en, wr1_en;
  logic [DATA_W-1:0] mem_q [DEPTH];

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk_i     (clk),
    .rst_ni    (rst),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  always_comb begin
    wr0_en = we0 && !busy && !(ZeroEn && (waddr0 == '0));
    wr1_en = we1 && !busy && !(ZeroEn && (waddr1 == '0));
  end

  // Port 1 is assigned last so it overrides port 0 on the same address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wr0_en) mem_q[waddr0] <= wdata0;
      if (wr1_en) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (!busy && re[k] && !(ZeroEn && (ra == '0))) begin
        if (we1 && (waddr1 == ra)) begin
          rd = wdata1;
        end else if (we0 && (waddr0 == ra)) begin
          rd = wdata0;
        end else begin
          rd = mem_q[ra];
        end
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp at default parameters: directed test-plan
// steps plus a randomized phase scored against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst;
  logic              we0, we1;
  logic [AW-1:0]     waddr0, waddr1;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NRD-1:0]    re;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic              busy;

  regfile_mp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NRD),
    .ZERO_REG(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .we0   (we0),
    .waddr0(waddr0),
    .wdata0(wdata0),
    .we1   (we1),
    .waddr1(waddr1),
    .wdata1(wdata1),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents the array must hold once clearing is done, plus
  // the number of clear cycles still outstanding.
  logic [DW-1:0] model [DEPTH];
  int            clr_left = 0;
  bit            chk_on   = 0;
  int            n_cmp    = 0;
  int            n_bad    = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int k);
    logic [AW-1:0] a;
    a = raddr[k*AW +: AW];
    if (clr_left > 0 || !re[k] || a == 0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return model[a];
  endfunction

  task automatic model_edge();
    if (!rst) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (we0 && waddr0 != 0) model[waddr0] = wdata0;
      if (we1 && waddr1 != 0) model[waddr1] = wdata1;
    end
  endtask

  // Called at a negedge with inputs already driven: check outputs, clock once.
  task automatic step();
    if (chk_on) begin
      #1;
      check("busy", {31'b0, busy}, {31'b0, clr_left > 0});
      for (int k = 0; k < NRD; k++) check($sformatf("rdata%0d", k), rdata[k*DW +: DW], exp_rd(k));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    re = '1; raddr = '0;
  endtask

  // Counts edges until busy drops; 100 bounds the wait.
  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    check(tag, cnt, 32'd32);
  endtask

  task automatic sweep_zero();
    we0 = 0; we1 = 0; re = '1;
    for (int i = 0; i < DEPTH; i++) begin
      raddr = {5'(DEPTH - 1 - i), 5'(i)};
      #1;
      check("sweep0", rdata[DW-1:0], '0);
      check("sweep1", rdata[2*DW-1:DW], '0);
      step();
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    @(negedge clk);
    step();
    chk_on = 1;
    step();
    step();
    #1;
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_rd0", rdata[DW-1:0], '0);

    // Release; a write attempted throughout the clear must be dropped.
    rst = 1;
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF; raddr = {5'd5, 5'd5};
    count_busy("clear_len");
    idle_inputs();
    raddr = {5'd5, 5'd5};
    #1;
    check("drop_busy_wr", rdata[DW-1:0], '0);
    sweep_zero();

    // Bypass, then array read on the following cycle.
    we0 = 1; waddr0 = 7; wdata0 = 32'h1234_5678; raddr = {5'd0, 5'd7};
    #1;
    check("bypass", rdata[DW-1:0], 32'h1234_5678);
    step();
    we0 = 0;
    #1;
    check("after_bypass", rdata[DW-1:0], 32'h1234_5678);
    step();

    // Dual write to the same address: port 1 wins.
    we0 = 1; we1 = 1; waddr0 = 9; waddr1 = 9;
    wdata0 = 32'hAAAA_AAAA; wdata1 = 32'h5555_5555; raddr = {5'd9, 5'd9};
    #1;
    check("conflict_same", rdata[DW-1:0], 32'h5555_5555);
    step();
    we0 = 0; we1 = 0;
    #1;
    check("conflict_next", rdata[2*DW-1:DW], 32'h5555_5555);
    step();

    // Zero register on both ports, then a disabled read port.
    we0 = 1; we1 = 1; waddr0 = 0; waddr1 = 0;
    wdata0 = 32'hFFFF_FFFF; wdata1 = 32'hFFFF_FFFF; raddr = '0;
    #1;
    check("zero_same", rdata, '0);
    step();
    we0 = 0; we1 = 0;
    #1;
    check("zero_after", rdata, '0);
    step();
    re = 2'b01; raddr = {5'd9, 5'd7};
    #1;
    check("re_off", rdata[2*DW-1:DW], '0);
    check("re_on", rdata[DW-1:0], 32'h1234_5678);
    step();

    // Randomized traffic, addresses biased to a small window to provoke clashes.
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      waddr0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      waddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata0 = $urandom; wdata1 = $urandom;
      re = 2'($urandom);
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end

    // Reset mid-clear restarts the full sequence.
    idle_inputs();
    rst = 0;
    step();
    rst = 1;
    for (int i = 0; i < 10; i++) step();
    rst = 0;
    step();
    rst = 1;
    count_busy("restart_len");
    sweep_zero();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
